des_key_sched_ctrl: RTL and testbench

Sequential DES key-schedule controller. It latches a 64-bit key on `start`, holds the 28-bit C/D halves in registers, and issues one 48-bit round subkey per accepted round. The subkeys come out in encrypt order (K1..K16) or decrypt order (K16..K1). It sits between the top-level control and the round datapath, and replaces the fully unrolled 16-subkey generator where area matters.

---
 rtl/des_key_sched_ctrl_if.sv | 44 ++++
 rtl/des_key_sched_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_des_key_sched_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_key_sched_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : des_key_sched_ctrl_if
// Description : Handshake and bus bundle of the sequential DES key-schedule
//               controller.
//               master : top-level control side. Drives start, decrypt, key,
//                        abort and round_ready. Observes the subkey stream.
//               slave  : the key-schedule controller itself.
//               Signals:
//                 start       - begin a schedule (sampled in IDLE)
//                 decrypt     - 0 = K1..K16, 1 = K16..K1 (sampled with start)
//                 key[63:0]   - DES key with parity bits (sampled with start)
//                 abort       - synchronous cancel back to IDLE
//                 round_ready - round datapath consumes the current subkey
//                 round_valid - subkey / round_idx are valid
//                 round_idx   - datapath round number 0..15
//                 subkey      - 48-bit PC-2 output of the C/D registers
//                 busy        - schedule in progress (ROUND or DONE)
//                 done        - one-cycle pulse after round 15 is accepted
// Revision    : 1.0 - initial release
// ============================================================================
interface des_key_sched_ctrl_if;
  logic        start;
  logic        decrypt;
  logic [63:0] key;
  logic        abort;
  logic        round_ready;
  logic        round_valid;
  logic [3:0]  round_idx;
  logic [47:0] subkey;
  logic        busy;
  logic        done;

  modport master (
    output start, decrypt, key, abort, round_ready,
    input  round_valid, round_idx, subkey, busy, done
  );

  modport slave (
    input  start, decrypt, key, abort, round_ready,
    output round_valid, round_idx, subkey, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/des_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : des_key_sched_ctrl
// Description : Sequential DES key schedule. The controller latches the key on
//               start and keeps the 28-bit C/D halves in registers. It presents
//               one 48-bit subkey per round, with a valid/ready handshake
//               toward the round datapath. Subkeys come out in encrypt order
//               (K1..K16) or decrypt order (K16..K1).
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - des_key_sched_ctrl_if.slave (see interface header)
// Revision    : 1.0 - initial release
// ============================================================================
module des_key_sched_ctrl (
  input  logic                  clk,
  input  logic                  rst_n,
  des_key_sched_ctrl_if.slave   bus
);

  // PC-1 / PC-2 tables in the standard 1-based, MSB-first DES bit numbering.
  // The first table entry sits in the most significant 6-bit slot.
  localparam int PC1_BITS = 56 * 6;
  localparam int PC2_BITS = 48 * 6;

  localparam logic [PC1_BITS-1:0] PC1_TAB = {
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [PC2_BITS-1:0] PC2_TAB = {
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // Shift schedule s[1..16]: bit (i-1) set means round i rotates by 2.
  localparam logic [15:0] SHIFT2 = 16'h7EFC;

  // DES bit p (1-based from MSB) of a 64-bit word is index 64-p, which equals
  // -p modulo 64 in a 6-bit index.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [PC1_BITS-1:0] t;
    logic [55:0]         o;
    logic [5:0]          p;
    t = PC1_TAB;
    o = '0;
    for (int j = 0; j < 56; j++) begin
      p = t[PC1_BITS-1 -: 6];
      o = {o[54:0], k[6'd0 - p]};
      t = t << 6;
    end
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [PC2_BITS-1:0] t;
    logic [47:0]         o;
    logic [5:0]          p;
    t = PC2_TAB;
    o = '0;
    for (int j = 0; j < 48; j++) begin
      p = t[PC2_BITS-1 -: 6];
      o = {o[46:0], cd[6'd56 - p]};
      t = t << 6;
    end
    return o;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ROUND = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [27:0] r_c, r_d, w_c_nxt, w_d_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic        r_dir, w_dir_nxt;
  logic [55:0] w_pc1;
  logic        w_accept;

  assign w_pc1    = pc1(bus.key);
  assign w_accept = (r_state == ROUND) && bus.round_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_c_nxt         = r_c;
    w_d_nxt         = r_d;
    w_idx_nxt       = r_idx;
    w_dir_nxt       = r_dir;
    bus.round_valid = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.round_idx   = r_idx;
    bus.subkey      = pc2({r_c, r_d});

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = ROUND;
          w_idx_nxt   = 4'd0;
          w_dir_nxt   = bus.decrypt;
          // Decrypt starts from C16/D16, which equal the unrotated C0/D0.
          if (bus.decrypt) begin
            w_c_nxt = w_pc1[55:28];
            w_d_nxt = w_pc1[27:0];
          end else begin
            w_c_nxt = rotl(w_pc1[55:28], SHIFT2[0]);
            w_d_nxt = rotl(w_pc1[27:0],  SHIFT2[0]);
          end
        end
      end
      ROUND: begin
        bus.round_valid = 1'b1;
        bus.busy        = 1'b1;
        if (w_accept) begin
          if (r_idx == 4'd15) begin
            // Registers already hold C16/D16 (encrypt) or C1/D1 (decrypt).
            w_state_nxt = DONE;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
            if (r_dir) begin
              // Undo the shift that produced the subkey just consumed.
              w_c_nxt = rotr(r_c, SHIFT2[~r_idx]);
              w_d_nxt = rotr(r_d, SHIFT2[~r_idx]);
            end else begin
              w_c_nxt = rotl(r_c, SHIFT2[r_idx + 4'd1]);
              w_d_nxt = rotl(r_d, SHIFT2[r_idx + 4'd1]);
            end
          end
        end
      end
      DONE: begin
        bus.busy    = 1'b1;
        bus.done    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Abort wins over start and acceptance. The datapath registers hold.
    if (bus.abort) begin
      w_state_nxt = IDLE;
      w_c_nxt     = r_c;
      w_d_nxt     = r_d;
      w_idx_nxt   = r_idx;
      w_dir_nxt   = r_dir;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_c     <= '0;
      r_d     <= '0;
      r_idx   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_d     <= w_d_nxt;
      r_idx   <= w_idx_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_des_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_des_key_sched_ctrl
// Description : Scoreboard bench for des_key_sched_ctrl. Stimulus pushes the
//               expected subkey stream into a queue. A negedge monitor pops
//               one entry per accepted round and per done pulse. The
//               reference is an unrolled generator that uses cumulative
//               rotations, with textbook subkeys pinned for the classic key.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_des_key_sched_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  des_key_sched_ctrl_if bus();

  des_key_sched_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_done;
    logic [3:0]  idx;
    logic [47:0] sk;
  } exp_t;

  exp_t sb[$];

  localparam logic [63:0] CLASSIC_KEY = 64'h1334_5779_9BBC_DFF1;
  localparam logic [47:0] CLASSIC_K1  = 48'h1B02_EFFC_7072;
  localparam logic [47:0] CLASSIC_K16 = 48'hCB3D_8B0E_17F5;

  localparam int PC1_T [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
    19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
    14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic kbit(input logic [63:0] k, input int p);
    logic [63:0] t;
    t = k << (p - 1);
    return t[63];
  endfunction

  function automatic logic cdbit(input logic [55:0] cd, input int p);
    logic [55:0] t;
    t = cd << (p - 1);
    return t[55];
  endfunction

  // Subkey Kr (r = 1..16) from the unrolled generator.
  function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int r);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] o;
    int tot;
    c = '0; d = '0; o = '0; tot = 0;
    for (int j = 0; j < 28; j++) begin
      c = {c[26:0], kbit(k, PC1_T[j])};
      d = {d[26:0], kbit(k, PC1_T[j+28])};
    end
    for (int i = 0; i < r; i++) tot += SHIFTS[i];
    c = (c << tot) | (c >> (28 - tot));
    d = (d << tot) | (d >> (28 - tot));
    cd = {c, d};
    for (int j = 0; j < 48; j++) o = {o[46:0], cdbit(cd, PC2_T[j])};
    return o;
  endfunction

  function automatic logic [47:0] expected(input logic [63:0] k, input logic dec, input int i);
    int r;
    logic [47:0] v;
    r = dec ? 16 - i : i + 1;
    v = ref_subkey(k, r);
    if (k == CLASSIC_KEY && r == 1)  v = CLASSIC_K1;
    if (k == CLASSIC_KEY && r == 16) v = CLASSIC_K16;
    return v;
  endfunction

  task automatic push_rounds(input logic [63:0] k, input logic dec, input int n, input bit with_done);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.is_done = 1'b0;
      e.idx     = 4'(i);
      e.sk      = expected(k, dec, i);
      sb.push_back(e);
    end
    if (with_done) begin
      e.is_done = 1'b1;
      e.idx     = 4'd0;
      e.sk      = '0;
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  bit          stalled_prev = 1'b0;
  logic [47:0] prev_sk;
  logic [3:0]  prev_idx;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev && bus.round_valid) begin
        check("stall_subkey_stable", bus.subkey, prev_sk);
        check("stall_idx_stable", bus.round_idx, prev_idx);
      end
      if (bus.round_valid && bus.round_ready && !bus.abort) begin
        check("round_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("round_not_done_slot", e.is_done, 0);
          check("round_idx", bus.round_idx, e.idx);
          check("subkey", bus.subkey, e.sk);
        end
      end
      if (bus.done) begin
        check("done_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("done_slot", e.is_done, 1);
        end
      end
      stalled_prev = bus.round_valid && !bus.round_ready && !bus.abort;
      prev_sk      = bus.subkey;
      prev_idx     = bus.round_idx;
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_sched(input logic [63:0] k, input logic dec, input bit rnd, input bit chk_lat);
    int n;
    bus.key         = k;
    bus.decrypt     = dec;
    bus.start       = 1'b1;
    bus.round_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    push_rounds(k, dec, 16, 1'b1);
    tick();
    bus.start   = 1'b0;
    bus.key     = ~k;
    bus.decrypt = ~dec;
    check("valid_after_start", bus.round_valid, 1);
    check("busy_in_round", bus.busy, 1);
    n = 1;
    while (!bus.done && n < 300) begin
      if (rnd) bus.round_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("done_seen", bus.done, 1);
    if (chk_lat) check("done_latency", n, 17);
    // start raised during DONE must be ignored
    bus.start = 1'b1;
    bus.key   = {$urandom, $urandom};
    tick();
    bus.start = 1'b0;
    check("idle_after_done_valid", bus.round_valid, 0);
    check("idle_after_done_busy", bus.busy, 0);
    check("done_one_cycle", bus.done, 0);
  endtask

  initial begin
    logic [63:0] k;
    int n;
    int walk_bits [4] = '{63, 56, 36, 8};
    bus.start = 1'b0; bus.decrypt = 1'b0; bus.key = '0;
    bus.abort = 1'b0; bus.round_ready = 1'b0;

    #2;
    check("rst_valid", bus.round_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_idx", bus.round_idx, 0);
    check("rst_subkey", bus.subkey, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_sched(64'h0, 1'b0, 1'b0, 1'b1);
    run_sched(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
    run_sched(CLASSIC_KEY, 1'b0, 1'b0, 1'b1);
    run_sched(CLASSIC_KEY, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      k = 64'h1 << walk_bits[i];
      run_sched(k, 1'(i), 1'b0, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      k = {$urandom, $urandom};
      run_sched(k, 1'(i), 1'b0, 1'b1);
    end

    // stalled handshakes
    run_sched({$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
    run_sched({$urandom, $urandom}, 1'b1, 1'b1, 1'b0);
    run_sched(CLASSIC_KEY, 1'b0, 1'b1, 1'b0);

    // abort at round 7, with a stray start during ROUND
    k = 64'hA5C3_0F96_1E2D_3C4B;
    bus.key = k; bus.decrypt = 1'b1; bus.start = 1'b1; bus.round_ready = 1'b1;
    push_rounds(k, 1'b1, 7, 1'b0);
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.round_idx != 4'd7 && n < 50) begin
      if (bus.round_idx == 4'd3) begin
        bus.start = 1'b1; bus.key = ~k; bus.decrypt = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      n++;
    end
    bus.start = 1'b0;
    check("reach_round7", bus.round_idx, 7);
    check("valid_round7", bus.round_valid, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_valid", bus.round_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_no_done", bus.done, 0);
    check("abort_cd_hold", bus.subkey, expected(k, 1'b1, 7));
    tick();
    check("abort_no_done_later", bus.done, 0);
    // abort beats start in IDLE
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("abort_over_start", bus.round_valid, 0);
    run_sched(k, 1'b1, 1'b0, 1'b1);

    // asynchronous reset in the middle of round 4
    k = 64'h0123_4567_89AB_CDEF;
    bus.key = k; bus.decrypt = 1'b0; bus.start = 1'b1; bus.round_ready = 1'b1;
    push_rounds(k, 1'b0, 4, 1'b0);
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.round_idx != 4'd4 && n < 50) begin
      tick();
      n++;
    end
    check("reach_round4", bus.round_idx, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.round_valid, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_idx", bus.round_idx, 0);
    check("arst_subkey", bus.subkey, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", bus.round_valid, 0);
    run_sched(64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 1'b1);
    run_sched(64'hFEDC_BA98_7654_3210, 1'b1, 1'b1, 1'b0);

    repeat (3) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
